// File: rtl/johnson_decoder_8_bit.sv
// Receive-side Johnson code decoder: checks legality, decodes to a 4-bit index,
// tracks sequence lock and counts integrity errors. Outputs float when disabled.
module johnson_decoder_8_bit #(
    parameter int LOCK_COUNT = 3,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Enable_In,
    input  logic [7:0] Code_In,
    input  logic       Code_Valid_In,
    input  logic       Clear_Errors_In,
    output logic [3:0] Decoded_Value_Out,
    output logic       Decoded_Valid_Out,
    output logic       Code_Legal_Flag_Out,
    output logic       Step_Error_Flag_Out,
    output logic       Locked_Flag_Out,
    output logic [7:0] Error_Count_Out
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] match_q, match_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] value_q, value_d;
    logic       legal_q, legal_d;
    logic       valid_q, valid_d;
    logic       step_q, step_d;
    logic [7:0] err_count_q;
    logic       err_event;

    logic [6:0] pair_diff;
    logic       code_legal;
    logic [3:0] ones;
    logic [3:0] index;
    logic       in_seq;
    logic [3:0] match_inc;

    // A legal word has at most one adjacent-bit transition: zero or one bits set in pair_diff.
    assign pair_diff  = Code_In[6:0] ^ Code_In[7:1];
    assign code_legal = ((pair_diff & (pair_diff - 7'd1)) == 7'd0);
    assign ones       = 4'($countones(Code_In));

    always_comb begin
        if (!Code_In[7])
            index = ones;
        else if (Code_In == 8'hFF)
            index = 4'd8;
        else
            index = 4'd0 - ones;
    end

    assign in_seq    = (index == prev_q + 4'd1) || (ALLOW_HOLD && (index == prev_q));
    assign match_inc = match_q + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        match_d   = match_q;
        prev_d    = prev_q;
        value_d   = value_q;
        legal_d   = legal_q;
        valid_d   = 1'b0;
        step_d    = 1'b0;
        err_event = 1'b0;

        if (Code_Valid_In) begin
            legal_d = code_legal;
            if (!code_legal) begin
                step_d    = 1'b1;
                err_event = 1'b1;
                state_d   = UNLOCKED;
                match_d   = 4'd0;
            end else begin
                value_d = index;
                valid_d = 1'b1;
                prev_d  = index;
                case (state_q)
                    UNLOCKED: begin
                        state_d = ACQUIRE;
                        match_d = 4'd0;
                    end
                    ACQUIRE: begin
                        if (in_seq) begin
                            match_d = match_inc;
                            if (match_inc == 4'(LOCK_COUNT))
                                state_d = LOCKED;
                        end else begin
                            match_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            step_d    = 1'b1;
                            err_event = 1'b1;
                            state_d   = ACQUIRE;
                            match_d   = 4'd0;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        match_d = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= UNLOCKED;
            match_q <= 4'd0;
            prev_q  <= 4'd0;
            value_q <= 4'd0;
            legal_q <= 1'b0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            prev_q  <= prev_d;
            value_q <= value_d;
            legal_q <= legal_d;
            valid_q <= valid_d;
            step_q  <= step_d;
        end
    end

    // Clear takes effect before counting, so a simultaneous error leaves the count at 1.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In)
            err_count_q <= 8'd0;
        else if (Clear_Errors_In)
            err_count_q <= err_event ? 8'd1 : 8'd0;
        else if (err_event && (err_count_q != 8'hFF))
            err_count_q <= err_count_q + 8'd1;
    end

    assign Decoded_Value_Out   = Enable_In ? value_q : 4'bzzzz;
    assign Decoded_Valid_Out   = Enable_In ? valid_q : 1'bz;
    assign Code_Legal_Flag_Out = Enable_In ? legal_q : 1'bz;
    assign Step_Error_Flag_Out = Enable_In ? step_q : 1'bz;
    assign Locked_Flag_Out     = Enable_In ? (state_q == LOCKED) : 1'bz;
    assign Error_Count_Out     = Enable_In ? err_count_q : 8'bzzzzzzzz;

endmodule
